mmu_tlb: RTL and testbench

Parametrised MIPS32 address-translation unit that replaces the fixed-map translator in the memory stage. kseg0 and kseg1 keep their direct mapping. kuseg, kseg2 and kseg3 are translated through a fully-associative, software-managed TLB with `TLB_ENTRIES` entries and 4 KB pages. The unit serves one instruction port and one data port, each with a registered one-cycle result, and services the CP0 TLBWI, TLBWR, TLBP and TLBR operations.

---
 rtl/mmu_tlb_if.sv | 29 ++
 rtl/mmu_tlb.sv | 101 ++++++++++
 tb/tb_mmu_tlb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mmu_tlb_if.sv
// mmu_tlb_if: lookup ports, CP0 TLB operations and results of the MIPS32 translation unit.
interface mmu_tlb_if #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W = $clog2(TLB_ENTRIES)
) ();
  logic inst_req, inst_resp_valid, inst_uncached, inst_refill, inst_invalid;
  logic [31:0] inst_vaddr, inst_paddr;
  logic data_req, data_wr, data_resp_valid, data_uncached, data_refill, data_invalid, data_modified;
  logic [31:0] data_vaddr, data_paddr;
  logic [7:0] asid;
  logic k0_uncached, tlb_we, tlb_wr_random, tlbp_req, tlbp_done, tlbp_hit, tlbr_req, tlbr_done;
  logic [IDX_W-1:0] tlb_index, wired, random, tlbp_index;
  logic [77:0] tlb_wdata, tlbr_rdata;
  logic [31:0] tlbp_entryhi;
  modport master (
    output inst_req, inst_vaddr, data_req, data_vaddr, data_wr, asid, k0_uncached,
           tlb_we, tlb_wr_random, tlb_index, tlb_wdata, wired, tlbp_req, tlbp_entryhi, tlbr_req,
    input  inst_resp_valid, inst_paddr, inst_uncached, inst_refill, inst_invalid,
           data_resp_valid, data_paddr, data_uncached, data_refill, data_invalid, data_modified,
           random, tlbp_done, tlbp_hit, tlbp_index, tlbr_done, tlbr_rdata
  );
  modport slave (
    input  inst_req, inst_vaddr, data_req, data_vaddr, data_wr, asid, k0_uncached,
           tlb_we, tlb_wr_random, tlb_index, tlb_wdata, wired, tlbp_req, tlbp_entryhi, tlbr_req,
    output inst_resp_valid, inst_paddr, inst_uncached, inst_refill, inst_invalid,
           data_resp_valid, data_paddr, data_uncached, data_refill, data_invalid, data_modified,
           random, tlbp_done, tlbp_hit, tlbp_index, tlbr_done, tlbr_rdata
  );
endinterface

// File: rtl/mmu_tlb.sv
// mmu_tlb: MIPS32 translation with direct kseg0/kseg1 and a fully-associative software-managed TLB.
module mmu_tlb #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W = $clog2(TLB_ENTRIES)
) (
  input logic clk,
  input logic resetn,
  mmu_tlb_if.slave bus
);
  typedef struct packed {
    logic [31:0] pa;
    logic unc, refill, invalid, modified;
  } res_t;
  logic [77:0] tlb_q [TLB_ENTRIES];
  logic [IDX_W-1:0] random_q, p_idx_q;
  res_t inst_d, data_d, inst_q, data_q;
  logic inst_v_q, data_v_q, p_done_q, p_hit_q, r_done_q;
  logic [IDX_W:0] probe_d;
  logic [77:0] rdata_q;
  // Returns {hit, index}; descending scan leaves the lowest matching index.
  function automatic logic [IDX_W:0] find(input logic [77:0] t [TLB_ENTRIES],
                                          input logic [18:0] vpn2, input logic [7:0] as);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (t[i][77:59] == vpn2 && (t[i][50] || t[i][58:51] == as)) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction
  function automatic res_t xlate(input logic [77:0] t [TLB_ENTRIES], input logic [31:0] va,
                                 input logic wr, input logic [7:0] as, input logic k0u);
    res_t r;
    logic [IDX_W:0] f;
    logic [77:0] e;
    logic [24:0] h;
    r = '0;
    f = find(t, va[31:13], as);
    e = t[f[IDX_W-1:0]];
    h = va[12] ? e[24:0] : e[49:25];
    if (va[31:30] == 2'b10) begin
      r.pa = {3'b0, va[28:0]};
      r.unc = va[29] | k0u;
    end
    else if (!f[IDX_W]) r.refill = 1'b1;
    else if (!h[0]) r.invalid = 1'b1;
    else if (wr && !h[1]) r.modified = 1'b1;
    else begin
      r.pa = {h[24:5], va[11:0]};
      r.unc = h[4:2] == 3'd2;
    end
    return r;
  endfunction
  always_comb begin
    inst_d = xlate(tlb_q, bus.inst_vaddr, 1'b0, bus.asid, bus.k0_uncached);
    data_d = xlate(tlb_q, bus.data_vaddr, bus.data_wr, bus.asid, bus.k0_uncached);
    probe_d = find(tlb_q, bus.tlbp_entryhi[31:13], bus.tlbp_entryhi[7:0]);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
      random_q <= IDX_W'(TLB_ENTRIES - 1);
      inst_q <= '0;
      data_q <= '0;
      inst_v_q <= 1'b0;
      data_v_q <= 1'b0;
      p_done_q <= 1'b0;
      p_hit_q <= 1'b0;
      p_idx_q <= '0;
      r_done_q <= 1'b0;
      rdata_q <= '0;
    end
    else begin
      if (bus.tlb_we) tlb_q[bus.tlb_wr_random ? random_q : bus.tlb_index] <= bus.tlb_wdata;
      random_q <= ((bus.tlb_we && !bus.tlb_wr_random) || random_q <= bus.wired)
                  ? IDX_W'(TLB_ENTRIES - 1) : random_q - 1'b1;
      inst_v_q <= bus.inst_req;
      data_v_q <= bus.data_req;
      if (bus.inst_req) inst_q <= inst_d;
      if (bus.data_req) data_q <= data_d;
      p_done_q <= bus.tlbp_req;
      if (bus.tlbp_req) {p_hit_q, p_idx_q} <= probe_d;
      r_done_q <= bus.tlbr_req;
      if (bus.tlbr_req) rdata_q <= tlb_q[bus.tlb_index];
    end
  assign bus.inst_resp_valid = inst_v_q;
  assign bus.inst_paddr = inst_q.pa;
  assign bus.inst_uncached = inst_q.unc;
  assign bus.inst_refill = inst_q.refill;
  assign bus.inst_invalid = inst_q.invalid;
  assign bus.data_resp_valid = data_v_q;
  assign bus.data_paddr = data_q.pa;
  assign bus.data_uncached = data_q.unc;
  assign bus.data_refill = data_q.refill;
  assign bus.data_invalid = data_q.invalid;
  assign bus.data_modified = data_q.modified;
  assign bus.random = random_q;
  assign bus.tlbp_done = p_done_q;
  assign bus.tlbp_hit = p_hit_q;
  assign bus.tlbp_index = p_idx_q;
  assign bus.tlbr_done = r_done_q;
  assign bus.tlbr_rdata = rdata_q;
endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: scoreboard bench for mmu_tlb; expected results are queued at issue, checked on valid/done.
module tb_mmu_tlb;
  localparam int N = 16;
  localparam int IW = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  mmu_tlb_if #(.TLB_ENTRIES(N)) bus ();
  mmu_tlb #(.TLB_ENTRIES(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [35:0] iq[$], dq[$];
  logic [IW:0] pq[$];
  logic [77:0] rq[$];
  logic [IW:0] pe;
  logic [4:0] rexp;
  logic [31:0] va;
  logic [77:0] e3, e7, e9;
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] res(input logic [31:0] pa, input logic u, rf, iv, md);
    return {pa, u, rf, iv, md};
  endfunction
  function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] as, input logic g,
      input logic [19:0] p0, input logic [2:0] c0, input logic d0, v0,
      input logic [19:0] p1, input logic [2:0] c1, input logic d1, v1);
    return {vpn2, as, g, p0, c0, d0, v0, p1, c1, d1, v1};
  endfunction
  always @(negedge clk) begin
    if (bus.inst_resp_valid) begin
      if (iq.size() == 0) chk("inst_extra", 1, 0);
      else chk("inst", {bus.inst_paddr, bus.inst_uncached, bus.inst_refill, bus.inst_invalid, 1'b0}, iq.pop_front());
    end
    if (bus.data_resp_valid) begin
      if (dq.size() == 0) chk("data_extra", 1, 0);
      else chk("data", {bus.data_paddr, bus.data_uncached, bus.data_refill, bus.data_invalid, bus.data_modified}, dq.pop_front());
    end
    if (bus.tlbp_done) begin
      if (pq.size() == 0) chk("probe_extra", 1, 0);
      else begin
        pe = pq.pop_front();
        if (pe[IW]) chk("probe_hit", {bus.tlbp_hit, bus.tlbp_index}, pe);
        else chk("probe_miss", bus.tlbp_hit, 0);
      end
    end
    if (bus.tlbr_done) begin
      if (rq.size() == 0) chk("read_extra", 1, 0);
      else chk("tlbr", bus.tlbr_rdata, rq.pop_front());
    end
  end
  task automatic idle();
    bus.inst_req = 0; bus.data_req = 0; bus.data_wr = 0; bus.tlb_we = 0;
    bus.tlb_wr_random = 0; bus.tlbp_req = 0; bus.tlbr_req = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1 idle();
  endtask
  task automatic ilook(input logic [31:0] a, input logic [35:0] exp);
    bus.inst_req = 1; bus.inst_vaddr = a; iq.push_back(exp);
  endtask
  task automatic dlook(input logic [31:0] a, input logic wr, input logic [35:0] exp);
    bus.data_req = 1; bus.data_vaddr = a; bus.data_wr = wr; dq.push_back(exp);
  endtask
  task automatic wi(input logic [IW-1:0] idx, input logic [77:0] e);
    bus.tlb_we = 1; bus.tlb_wr_random = 0; bus.tlb_index = idx; bus.tlb_wdata = e;
  endtask
  task automatic probe(input logic [31:0] key, input logic [IW:0] exp);
    bus.tlbp_req = 1; bus.tlbp_entryhi = key; pq.push_back(exp);
  endtask
  task automatic rd(input logic [IW-1:0] idx, input logic [77:0] exp);
    bus.tlbr_req = 1; bus.tlb_index = idx; rq.push_back(exp);
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_inst"}, {bus.inst_resp_valid, bus.inst_paddr, bus.inst_uncached, bus.inst_refill, bus.inst_invalid}, 0);
    chk({tag, "_data"}, {bus.data_resp_valid, bus.data_paddr, bus.data_uncached, bus.data_refill,
        bus.data_invalid, bus.data_modified}, 0);
    chk({tag, "_cp0"}, {bus.tlbp_done, bus.tlbp_hit, bus.tlbp_index, bus.tlbr_done, bus.tlbr_rdata}, 0);
    chk({tag, "_random"}, bus.random, 15);
  endtask
  initial begin
    idle();
    bus.inst_vaddr = 0; bus.data_vaddr = 0; bus.asid = 0; bus.k0_uncached = 0;
    bus.tlb_index = 0; bus.tlb_wdata = 0; bus.wired = 4; bus.tlbp_entryhi = 0;
    repeat (2) @(posedge clk);
    #1 chk_quiet("rst");
    @(negedge clk) resetn = 1;
    rexp = 15;
    chk("rand", bus.random, rexp);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rexp = (rexp <= 4) ? 5'd15 : rexp - 5'd1;
      chk("rand", bus.random, rexp);
    end
    @(posedge clk);
    #1;
    ilook(32'h9FC0_0000, res(32'h1FC0_0000, 0, 0, 0, 0));
    dlook(32'hBFAF_0000, 0, res(32'h1FAF_0000, 1, 0, 0, 0));
    step();
    bus.k0_uncached = 1;
    ilook(32'h8000_1234, res(32'h0000_1234, 1, 0, 0, 0));
    step();
    bus.k0_uncached = 0;
    va = 32'h0040_1ABC;
    bus.asid = 5;
    dlook(va, 0, res(0, 0, 1, 0, 0));
    step();
    e3 = mk(19'h00200, 8'd5, 0, 20'h0, 3'd0, 0, 0, 20'h12345, 3'd3, 1, 1);
    wi(3, e3);
    step();
    dlook(va, 0, res(32'h1234_5ABC, 0, 0, 0, 0));
    ilook(va, res(32'h1234_5ABC, 0, 0, 0, 0));
    step();
    bus.asid = 6;
    dlook(va, 0, res(0, 0, 1, 0, 0));
    step();
    bus.asid = 5;
    e3 = mk(19'h00200, 8'd5, 0, 20'h0, 3'd0, 0, 0, 20'h12345, 3'd3, 0, 1);
    wi(3, e3);
    step();
    dlook(va, 1, res(0, 0, 0, 0, 1));
    step();
    dlook(va, 0, res(32'h1234_5ABC, 0, 0, 0, 0));
    step();
    e3 = mk(19'h00200, 8'd5, 0, 20'h0, 3'd0, 0, 0, 20'h12345, 3'd3, 0, 0);
    wi(3, e3);
    step();
    dlook(va, 0, res(0, 0, 0, 1, 0));
    step();
    dlook(32'h0080_0000, 0, res(0, 0, 1, 0, 0));
    step();
    e7 = mk(19'h12345, 8'd9, 1, 20'h0ABCD, 3'd2, 1, 1, 20'h11111, 3'd3, 1, 1);
    wi(7, e7);
    step();
    probe({19'h12345, 5'h0, 8'h01}, {1'b1, 4'd7});
    ilook(32'h2468_A123, res(32'h0ABC_D123, 1, 0, 0, 0));
    step();
    probe({19'h7FFFF, 13'h0}, 5'h0);
    step();
    e9 = mk(19'h55555, 8'h33, 0, 20'hAAAAA, 3'd5, 1, 1, 20'h0F0F0, 3'd1, 0, 1);
    begin
      int n;
      n = 0;
      while (bus.random !== 4'd9 && n < 40) begin
        step();
        n++;
      end
      chk("wait_random9", n < 40, 1);
    end
    bus.tlb_we = 1; bus.tlb_wr_random = 1; bus.tlb_index = 2; bus.tlb_wdata = e9;
    step();
    rd(9, e9);
    step();
    rd(3, e3);
    step();
    e3 = mk(19'h00200, 8'd5, 0, 20'h0, 3'd0, 0, 0, 20'h12345, 3'd3, 1, 1);
    wi(3, e3);
    step();
    wi(3, mk(19'h00200, 8'd5, 0, 20'h0, 3'd0, 0, 0, 20'h54321, 3'd3, 1, 1));
    dlook(va, 0, res(32'h1234_5ABC, 0, 0, 0, 0));
    step();
    dlook(va, 0, res(32'h5432_1ABC, 0, 0, 0, 0));
    step();
    step();
    bus.inst_req = 1; bus.data_req = 1; bus.tlbp_req = 1; bus.tlbr_req = 1;
    #2 resetn = 0;
    idle();
    #1 chk_quiet("midrst");
    repeat (2) @(negedge clk);
    chk_quiet("midrst_hold");
    @(negedge clk) resetn = 1;
    @(posedge clk);
    #1 dlook(va, 0, res(0, 0, 1, 0, 0));
    rd(3, {27'h0, 1'b0, 25'h0, 25'h0} & 78'h0_0000_0400_0002_0000_01);
    step();
    repeat (3) step();
    chk("iq_left", iq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("pq_left", pq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

●
